// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the serial BCD/Excess-3 converter.
// Optional feature macro used by the converter: XS3_NINES_COMP_EN.
package bcd_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       MODE_BCD2XS3  = 1'b0;
    localparam logic       MODE_XS32BCD  = 1'b1;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;
    localparam logic [3:0] BCD_MAX       = 4'd9;
    localparam logic [3:0] XS3_MIN       = 4'd3;
    localparam logic [3:0] XS3_MAX       = 4'd12;
    localparam logic [3:0] XS3_OFFSET    = 4'd3;

endpackage

// File: rtl/xs3_digit_unit.sv
// Combinational single-digit BCD<->XS3 converter with invalid-code detection
// and optional nines'-complement of the result (i_comp).
module xs3_digit_unit
    import bcd_xs3_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_mode,
    input  logic       i_comp,
    output logic [3:0] o_result,
    output logic       o_err
);

    logic [3:0] w_res;
    logic       w_err;

    // Range-check the digit, convert it, optionally complement, and force 4'hF on bad codes
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        if (i_mode == MODE_BCD2XS3) begin
            if (i_digit > BCD_MAX) begin
                w_err = 1'b1;
            end else begin
                w_res = i_digit + XS3_OFFSET;
                if (i_comp) begin
                    // XS3 is self-complementing: XS3(9-d) is simply ~XS3(d)
                    w_res = ~w_res;
                end
            end
        end else begin
            if ((i_digit < XS3_MIN) || (i_digit > XS3_MAX)) begin
                w_err = 1'b1;
            end else begin
                w_res = i_digit - XS3_OFFSET;
                if (i_comp) begin
                    w_res = BCD_MAX - w_res;
                end
            end
        end
        if (w_err) begin
            w_res = DIGIT_INVALID;
        end
    end

    assign o_result = w_res;
    assign o_err    = w_err;

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Multi-digit BCD/XS3 converter: latches a packed word, converts one digit per
// clock through a shared xs3_digit_unit, then presents the result with valid/ready.
// Define XS3_NINES_COMP_EN to add the in_comp port (nines'-complemented results).
module bcd_xs3_serial_conv
    import bcd_xs3_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] in_data,
    input  logic                  in_mode,
`ifdef XS3_NINES_COMP_EN
    input  logic                  in_comp,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*N_DIGITS-1:0] out_data,
    output logic [N_DIGITS-1:0]   out_err,
    output logic                  out_err_any
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_data;
    logic                  r_mode;
    logic                  r_comp;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [4*N_DIGITS-1:0] r_out_data;
    logic [N_DIGITS-1:0]   r_out_err;
    logic                  r_err_any;

    logic [3:0]            w_digit;
    logic [3:0]            w_res;
    logic                  w_err;
    logic                  w_comp_in;

`ifdef XS3_NINES_COMP_EN
    assign w_comp_in = in_comp;
`else
    assign w_comp_in = 1'b0;
`endif

    assign w_digit = r_data[{r_idx, 2'b00} +: 4];

    xs3_digit_unit u_digit (
        .i_digit  (w_digit),
        .i_mode   (r_mode),
        .i_comp   (r_comp),
        .o_result (w_res),
        .o_err    (w_err)
    );

    // Control FSM: accept a word, walk the digit index, then hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_data      <= '0;
            r_mode      <= MODE_BCD2XS3;
            r_comp      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
            r_err_any   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data;
                        r_mode     <= in_mode;
                        r_comp     <= w_comp_in;
                        r_out_data <= '0;
                        r_out_err  <= '0;
                        r_err_any  <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_out_data[{r_idx, 2'b00} +: 4] <= w_res;
                    r_out_err[r_idx]                <= w_err;
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle folds the completed error vector into out_err_any
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_err_any   <= |r_out_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_err     = r_out_err;
    assign out_err_any = r_err_any;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Self-checking bench for bcd_xs3_serial_conv (N_DIGITS=4): directed vector
// table, backpressure and reset-abort sequences, and randomized words checked
// against an arithmetic digit model. Honours XS3_NINES_COMP_EN when defined.
module tb_bcd_xs3_serial_conv;

   localparam int N_DIGITS = 4;

   typedef struct {
      logic [15:0] data;
      logic        mode;
      logic        comp;
      logic [15:0] expData;
      logic [3:0]  expErr;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [15:0] inData;
   logic        inMode;
   logic        inComp;
   logic        outValid;
   logic        outReady;
   logic [15:0] outData;
   logic [3:0]  outErr;
   logic        outErrAny;

   int nCompared;
   int nMismatched;

   bcd_xs3_serial_conv #(.N_DIGITS(N_DIGITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (inValid),
      .in_ready    (inReady),
      .in_data     (inData),
      .in_mode     (inMode),
`ifdef XS3_NINES_COMP_EN
      .in_comp     (inComp),
`endif
      .out_valid   (outValid),
      .out_ready   (outReady),
      .out_data    (outData),
      .out_err     (outErr),
      .out_err_any (outErrAny)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and record the outcome
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Digit-by-digit arithmetic reference for a whole word
   function automatic void refModel(input logic [15:0] data, input logic mode, input logic comp,
                                    output logic [15:0] expData, output logic [3:0] expErr);
      int d;
      int r;
      bit ok;
      expData = '0;
      expErr  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         d = int'(data[i*4 +: 4]);
         if (mode == 1'b0) begin
            ok = (d <= 9);
            r  = comp ? ((9 - d) + 3) : ((d + 3) % 16);
         end else begin
            ok = (d >= 3) && (d <= 12);
            r  = comp ? (9 - (d - 3)) : (d - 3);
         end
         if (!ok) begin
            r         = 15;
            expErr[i] = 1'b1;
         end
         expData[i*4 +: 4] = 4'(r);
      end
   endfunction

   // Send one word, check latency and result, then complete the output handshake
   task automatic applyStimulus(input string name, input logic [15:0] data, input logic mode,
                                input logic comp, input logic [15:0] expData, input logic [3:0] expErr);
      int waitCnt;
      waitCnt = 0;
      @(negedge clk);
      while (!inReady && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput({name, ".inReady"}, 64'(inReady), 64'd1);
      inValid = 1'b1;
      inData  = data;
      inMode  = mode;
      inComp  = comp;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      waitCnt = 0;
      while (!outValid && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      checkOutput({name, ".latency"}, 64'(waitCnt), 64'(N_DIGITS + 1));
      checkOutput({name, ".data"}, 64'(outData), 64'(expData));
      checkOutput({name, ".err"}, 64'(outErr), 64'(expErr));
      checkOutput({name, ".errAny"}, 64'(outErrAny), 64'(|expErr));
      checkOutput({name, ".busy"}, 64'(inReady), 64'd0);
      @(negedge clk);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput({name, ".validDrop"}, 64'(outValid), 64'd0);
   endtask

   initial begin
      vec_t        vecs[$];
      logic [15:0] rData;
      logic        rMode;
      logic        rComp;
      logic [15:0] eData;
      logic [3:0]  eErr;
      int          waitCnt;
      bit          seenValid;

      nCompared   = 0;
      nMismatched = 0;
      inValid  = 1'b0;
      inData   = '0;
      inMode   = 1'b0;
      inComp   = 1'b0;
      outReady = 1'b0;
      rst_n    = 1'b0;

      vecs.push_back('{16'h1234, 1'b0, 1'b0, 16'h4567, 4'b0000});
      vecs.push_back('{16'h4567, 1'b1, 1'b0, 16'h1234, 4'b0000});
      vecs.push_back('{16'h3C3C, 1'b1, 1'b0, 16'h0909, 4'b0000});
      vecs.push_back('{16'h12A4, 1'b0, 1'b0, 16'h45F7, 4'b0010});
      vecs.push_back('{16'h2D55, 1'b1, 1'b0, 16'hFF22, 4'b1100});
      vecs.push_back('{16'h9090, 1'b0, 1'b0, 16'hC3C3, 4'b0000});
      vecs.push_back('{16'hC3C3, 1'b1, 1'b0, 16'h9090, 4'b0000});
      vecs.push_back('{16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b1111});
      vecs.push_back('{16'hFBAD, 1'b0, 1'b0, 16'hFFFF, 4'b1111});
      vecs.push_back('{16'hD2E1, 1'b1, 1'b0, 16'hFFFF, 4'b1111});
`ifdef XS3_NINES_COMP_EN
      vecs.push_back('{16'h1234, 1'b0, 1'b1, 16'hBA98, 4'b0000});
      vecs.push_back('{16'h4567, 1'b1, 1'b1, 16'h8765, 4'b0000});
      vecs.push_back('{16'h12A4, 1'b0, 1'b1, 16'hBAF8, 4'b0010});
`endif

      // Reset values
      #12;
      checkOutput("reset.inReady", 64'(inReady), 64'd1);
      checkOutput("reset.outValid", 64'(outValid), 64'd0);
      checkOutput("reset.outData", 64'(outData), 64'd0);
      checkOutput("reset.outErr", 64'(outErr), 64'd0);
      checkOutput("reset.outErrAny", 64'(outErrAny), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, vecs[i].comp,
                       vecs[i].expData, vecs[i].expErr);
      end

      // Backpressure: result held, a second word ignored while DONE
      @(negedge clk);
      inValid = 1'b1;
      inData  = 16'h1234;
      inMode  = 1'b0;
      inComp  = 1'b0;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      waitCnt = 0;
      while (!outValid && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      checkOutput("bp.valid", 64'(outValid), 64'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         inValid = 1'b1;
         inData  = 16'h9999;
         inMode  = 1'b1;
         checkOutput($sformatf("bp.hold%0d.valid", c), 64'(outValid), 64'd1);
         checkOutput($sformatf("bp.hold%0d.data", c), 64'(outData), 64'h4567);
         checkOutput($sformatf("bp.hold%0d.inReady", c), 64'(inReady), 64'd0);
      end
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput("bp.release.valid", 64'(outValid), 64'd0);
      checkOutput("bp.release.inReady", 64'(inReady), 64'd1);
      applyStimulus("bp.next", 16'h0246, 1'b0, 1'b0, 16'h3579, 4'b0000);

      // Reset during conversion aborts the word
      @(negedge clk);
      inValid = 1'b1;
      inData  = 16'h1234;
      inMode  = 1'b0;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("abort.partial", 64'(outData), 64'h0067);
      rst_n = 1'b0;
      #1;
      checkOutput("abort.outData", 64'(outData), 64'd0);
      checkOutput("abort.outErr", 64'(outErr), 64'd0);
      checkOutput("abort.outValid", 64'(outValid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seenValid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (outValid) seenValid = 1'b1;
      end
      checkOutput("abort.noOutput", 64'(seenValid), 64'd0);
      checkOutput("abort.inReady", 64'(inReady), 64'd1);

      // Randomized words against the reference model
      for (int n = 0; n < 24; n++) begin
         rData = 16'($urandom);
         rMode = 1'($urandom_range(0, 1));
`ifdef XS3_NINES_COMP_EN
         rComp = 1'($urandom_range(0, 1));
`else
         rComp = 1'b0;
`endif
         refModel(rData, rMode, rComp, eData, eErr);
         applyStimulus($sformatf("rand%0d", n), rData, rMode, rComp, eData, eErr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
